// File: rtl/rvcpu_bus_pkg.sv
// rtl/rvcpu_bus_pkg.sv - shared peripheral bus types and constants
package rvcpu_bus_pkg;

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} wbb_state_t;

    localparam logic [31:0] PERIPH_BASE = 32'h4000_0000;

    localparam int TIMER_IDX = 0;
    localparam int UART_IDX  = 1;
    localparam int GPIO_IDX  = 2;
    localparam int SPARE_IDX = 3;

endpackage

// File: rtl/wb_periph_bridge.sv
// rtl/wb_periph_bridge.sv - CPU load/store port to Wishbone classic peripheral bridge
module wb_periph_bridge #(
    parameter int          N_SLAVES    = 4,
    parameter logic [31:0] PERIPH_BASE = rvcpu_bus_pkg::PERIPH_BASE,
    parameter int          SLV_LSB     = 12,
    parameter int          TIMEOUT     = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req_i,
    output logic                  cpu_ready_o,
    input  logic                  cpu_we_i,
    input  logic [3:0]            cpu_be_i,
    input  logic [31:0]           cpu_addr_i,
    input  logic [31:0]           cpu_wdata_i,
    output logic                  cpu_rsp_valid_o,
    output logic [31:0]           cpu_rdata_o,
    output logic                  cpu_err_o,
    output logic [N_SLAVES-1:0]   wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [3:0]            wb_sel_o,
    output logic [31:0]           wb_adr_o,
    output logic [31:0]           wb_dat_o,
    input  logic [32*N_SLAVES-1:0] wb_dat_i,
    input  logic [N_SLAVES-1:0]   wb_ack_i
);
    import rvcpu_bus_pkg::*;

    localparam int IDXW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TAGL = SLV_LSB + IDXW;

    wbb_state_t            state, state_n;
    logic [CNTW-1:0]       cnt, cnt_n;
    logic [N_SLAVES-1:0]   cyc_n;
    logic                  stb_n, we_n, rsp_n, err_n;
    logic [3:0]            sel_n;
    logic [31:0]           adr_n, dat_n, rdata_n;

    logic [IDXW-1:0]       req_idx;
    logic                  req_hit;
    logic                  ack_sel;
    logic [31:0]           rd_sel;

    assign req_idx     = cpu_addr_i[SLV_LSB +: IDXW];
    assign req_hit     = (cpu_addr_i[31:TAGL] == PERIPH_BASE[31:TAGL]) && (32'(req_idx) < N_SLAVES);
    assign cpu_ready_o = (state == IDLE) && rst_n;

    // The latched one-hot cyc selects which slave's ack and data are honoured.
    always_comb begin
        ack_sel = 1'b0;
        rd_sel  = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (wb_cyc_o[k]) begin
                ack_sel = wb_ack_i[k];
                rd_sel  = wb_dat_i[32*k +: 32];
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cyc_n   = '0;
        stb_n   = 1'b0;
        we_n    = 1'b0;
        sel_n   = wb_sel_o;
        adr_n   = wb_adr_o;
        dat_n   = wb_dat_o;
        rsp_n   = 1'b0;
        rdata_n = cpu_rdata_o;
        err_n   = cpu_err_o;
        case (state)
            IDLE: begin
                if (cpu_req_i) begin
                    sel_n = cpu_be_i;
                    adr_n = cpu_addr_i;
                    dat_n = cpu_wdata_i;
                    if (!req_hit) begin
                        state_n = RESP;
                        rsp_n   = 1'b1;
                        err_n   = 1'b1;
                        rdata_n = '0;
                    end else begin
                        for (int k = 0; k < N_SLAVES; k++) begin
                            if (req_idx == IDXW'(k)) cyc_n[k] = 1'b1;
                        end
                        stb_n   = 1'b1;
                        we_n    = cpu_we_i;
                        cnt_n   = '0;
                        state_n = cpu_we_i ? WRITE : READ;
                    end
                end
            end
            WRITE: begin
                state_n = RESP;
                rsp_n   = 1'b1;
                err_n   = 1'b0;
                rdata_n = '0;
            end
            READ: begin
                if (ack_sel) begin
                    state_n = RESP;
                    rsp_n   = 1'b1;
                    err_n   = 1'b0;
                    rdata_n = rd_sel;
                end else if (cnt == CNTW'(TIMEOUT - 1)) begin
                    state_n = RESP;
                    rsp_n   = 1'b1;
                    err_n   = 1'b1;
                    rdata_n = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                    cyc_n = wb_cyc_o;
                    stb_n = 1'b1;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            wb_cyc_o        <= '0;
            wb_stb_o        <= 1'b0;
            wb_we_o         <= 1'b0;
            wb_sel_o        <= '0;
            wb_adr_o        <= '0;
            wb_dat_o        <= '0;
            cpu_rsp_valid_o <= 1'b0;
            cpu_rdata_o     <= '0;
            cpu_err_o       <= 1'b0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            wb_cyc_o        <= cyc_n;
            wb_stb_o        <= stb_n;
            wb_we_o         <= we_n;
            wb_sel_o        <= sel_n;
            wb_adr_o        <= adr_n;
            wb_dat_o        <= dat_n;
            cpu_rsp_valid_o <= rsp_n;
            cpu_rdata_o     <= rdata_n;
            cpu_err_o       <= err_n;
        end
    end

endmodule

// File: tb/tb_wb_periph_bridge.sv
// tb/tb_wb_periph_bridge.sv - self-checking bench for wb_periph_bridge
module tb_wb_periph_bridge;

    localparam int          N  = 4;
    localparam int          TO = 15;
    localparam logic [31:0] PB = 32'h4000_0000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cpu_req_i = 1'b0;
    logic            cpu_ready_o;
    logic            cpu_we_i = 1'b0;
    logic [3:0]      cpu_be_i = '0;
    logic [31:0]     cpu_addr_i = '0;
    logic [31:0]     cpu_wdata_i = '0;
    logic            cpu_rsp_valid_o;
    logic [31:0]     cpu_rdata_o;
    logic            cpu_err_o;
    logic [N-1:0]    wb_cyc_o;
    logic            wb_stb_o;
    logic            wb_we_o;
    logic [3:0]      wb_sel_o;
    logic [31:0]     wb_adr_o;
    logic [31:0]     wb_dat_o;
    logic [32*N-1:0] wb_dat_i;
    logic [N-1:0]    wb_ack_i;

    logic [N-1:0]    ack_q = '0;
    logic [N-1:0]    spur = '0;
    int              lat   [N];
    int              wcnt  [N];
    logic [31:0]     sdata [N];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_periph_bridge #(.N_SLAVES(N), .PERIPH_BASE(PB), .SLV_LSB(12), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_i(cpu_req_i), .cpu_ready_o(cpu_ready_o), .cpu_we_i(cpu_we_i),
        .cpu_be_i(cpu_be_i), .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
        .cpu_rsp_valid_o(cpu_rsp_valid_o), .cpu_rdata_o(cpu_rdata_o), .cpu_err_o(cpu_err_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    // Slave k acks a read once it has seen stb for lat[k] edges (0 = never), and keeps
    // acking while strobed, which yields the stale ack after the bridge drops stb.
    always_comb begin
        for (int k = 0; k < N; k++) wb_dat_i[32*k +: 32] = sdata[k];
    end
    assign wb_ack_i = ack_q | spur;

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (wb_cyc_o[k] && wb_stb_o && !wb_we_o) begin
                ack_q[k] <= (lat[k] != 0) && (wcnt[k] >= lat[k] - 1);
                wcnt[k]  <= wcnt[k] + 1;
            end else begin
                ack_q[k] <= 1'b0;
                wcnt[k]  <= 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one request and compares what happens against the outcome predicted from the
    // address map, slave ack latency and timeout rules.
    task automatic txn(input string tag, input logic [31:0] addr, input logic we,
                       input logic [3:0] be, input logic [31:0] wd, input logic [N-1:0] spur_mask);
        int          e_lat, e_stb, idx, n, g_lat, g_stb, g_rsp;
        logic        e_err, hit, g_err, g_we;
        logic [31:0] e_rd, g_rd, g_adr, g_dat;
        logic [N-1:0] e_cyc, g_cyc;
        logic [3:0]  g_sel;

        hit = (addr >= PB) && (addr < PB + 32'(N * 4096));
        idx = int'((addr - PB) / 4096);
        e_cyc = '0;
        e_stb = 0;
        e_rd  = '0;
        if (!hit) begin
            e_lat = 1;
            e_err = 1'b1;
        end else if (we) begin
            e_lat = 2;
            e_err = 1'b0;
            e_cyc = N'(1) << idx;
            e_stb = 1;
        end else begin
            e_cyc = N'(1) << idx;
            if (lat[idx] != 0 && lat[idx] + 1 <= TO) begin
                e_lat = lat[idx] + 2;
                e_err = 1'b0;
                e_rd  = sdata[idx];
                e_stb = lat[idx] + 1;
            end else begin
                e_lat = TO + 1;
                e_err = 1'b1;
                e_stb = TO;
            end
        end

        @(negedge clk);
        chk({tag, ".ready"}, 32'(cpu_ready_o), 32'd1);
        cpu_req_i   = 1'b1;
        cpu_addr_i  = addr;
        cpu_we_i    = we;
        cpu_be_i    = be;
        cpu_wdata_i = wd;
        spur        = spur_mask;
        @(posedge clk);

        g_lat = 0; g_stb = 0; g_rsp = 0; g_cyc = '0; g_err = 1'b0; g_rd = '0;
        g_we = 1'b0; g_adr = '0; g_dat = '0; g_sel = '0;
        for (n = 1; n <= e_lat + 3; n++) begin
            @(negedge clk);
            if (n == 1) begin
                cpu_req_i   = 1'b0;
                cpu_addr_i  = $urandom;
                cpu_wdata_i = $urandom;
                chk({tag, ".busy"}, 32'(cpu_ready_o), 32'd0);
            end
            if (wb_stb_o) begin
                g_stb++;
                g_cyc = g_cyc | wb_cyc_o;
                g_we  = wb_we_o;
                g_adr = wb_adr_o;
                g_dat = wb_dat_o;
                g_sel = wb_sel_o;
            end
            if (cpu_rsp_valid_o) begin
                g_rsp++;
                if (g_lat == 0) begin
                    g_lat = n;
                    g_err = cpu_err_o;
                    g_rd  = cpu_rdata_o;
                end
            end
        end
        spur = '0;

        chk({tag, ".lat"},   32'(g_lat), 32'(e_lat));
        chk({tag, ".err"},   32'(g_err), 32'(e_err));
        chk({tag, ".rdata"}, g_rd, e_rd);
        chk({tag, ".nrsp"},  32'(g_rsp), 32'd1);
        chk({tag, ".nstb"},  32'(g_stb), 32'(e_stb));
        chk({tag, ".cyc"},   32'(g_cyc), 32'(e_cyc));
        if (hit) begin
            chk({tag, ".adr"}, g_adr, addr);
            chk({tag, ".we"},  32'(g_we), 32'(we));
            if (we) begin
                chk({tag, ".dat"}, g_dat, wd);
                chk({tag, ".sel"}, 32'(g_sel), 32'(be));
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        int          s;

        for (int k = 0; k < N; k++) begin
            lat[k]   = 1;
            wcnt[k]  = 0;
            sdata[k] = '0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.ready", 32'(cpu_ready_o), 32'd0);
        chk("rst.cyc",   32'(wb_cyc_o), 32'd0);
        chk("rst.stb",   32'(wb_stb_o), 32'd0);
        chk("rst.rsp",   32'(cpu_rsp_valid_o), 32'd0);
        chk("rst.rdata", cpu_rdata_o, 32'd0);
        chk("rst.adr",   wb_adr_o, 32'd0);
        rst_n = 1'b1;

        // Directed cases
        txn("store_timer", 32'h4000_0000, 1'b1, 4'hF, 32'h0000_0003, '0);
        sdata[0] = 32'h1234_5678;
        lat[0]   = 1;
        txn("load_timer", 32'h4000_0004, 1'b0, 4'hF, 32'h0, '0);
        sdata[2] = 32'hCAFE_0002;
        lat[2]   = 2;
        txn("load_gpio_spur", 32'h4000_2008, 1'b0, 4'hF, 32'h0, 4'b0001);
        lat[3] = 0;
        txn("load_timeout", 32'h4000_3000, 1'b0, 4'hF, 32'h0, '0);
        txn("load_miss", 32'h5000_0000, 1'b0, 4'hF, 32'h0, '0);
        txn("store_miss", 32'h4000_4000, 1'b1, 4'h3, 32'hDEAD_BEEF, '0);

        // Reset in the middle of a read that would otherwise time out
        @(negedge clk);
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h4000_3010;
        cpu_we_i   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cpu_req_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrd.stb_before", 32'(wb_stb_o), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrd.cyc",   32'(wb_cyc_o), 32'd0);
        chk("midrd.stb",   32'(wb_stb_o), 32'd0);
        chk("midrd.rsp",   32'(cpu_rsp_valid_o), 32'd0);
        chk("midrd.ready", 32'(cpu_ready_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrd.rsp_after", 32'(cpu_rsp_valid_o), 32'd0);
        sdata[1] = 32'h0BAD_F00D;
        lat[1]   = 1;
        txn("post_reset_load", 32'h4000_1000, 1'b0, 4'hF, 32'h0, '0);

        // Randomized traffic against the address-map / latency model
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < N; k++) begin
                lat[k]   = $urandom_range(0, 17);
                sdata[k] = $urandom;
            end
            s = $urandom_range(0, N - 1);
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = PB + 32'(s * 4096) + {20'd0, 12'($urandom_range(0, 1023) * 4)};
            txn($sformatf("rnd%0d", i), a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                $urandom, N'($urandom) & ~(N'(1) << s));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
